// File: rtl/hash_job_sequencer.sv
// Job sequencer for the SHA-256 core: buffers scanner words, builds the single-block
// padded message per word, runs the core, and holds each digest until software acks it.
module hash_job_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  scan_data,
  input  logic         scan_valid,
  output logic         scan_ready,
  output logic [511:0] core_block,
  output logic         core_reset,
  output logic         core_start,
  input  logic         core_done,
  input  logic [255:0] core_hash,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ack,
  input  logic         err_clear,
  output logic         timeout_err,
  output logic         busy,
  output logic [15:0]  job_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_ABORT, S_HOLD
  } state_t;

  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic [511:0]     core_block_q, core_block_d;
  logic             core_reset_q, core_reset_d;
  logic             core_start_q, core_start_d;
  logic [255:0]     digest_q, digest_d;
  logic             digest_valid_q, digest_valid_d;
  logic             timeout_err_q, timeout_err_d;
  logic [15:0]      job_count_q, job_count_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             full, empty, push, pop, timeout_set;

  // Single-block SHA-256 padding for a 32-bit message: data, stop bit, zeros, bit length.
  function automatic logic [511:0] build_block(input logic [31:0] word);
    return {word, 1'b1, 415'b0, 64'd32};
  endfunction

  always_comb begin
    full  = (count_q == DEPTH_C);
    empty = (count_q == '0);
    push  = scan_valid && !full;
    pop   = (state_q == S_LOAD);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    state_d        = state_q;
    core_block_d   = core_block_q;
    core_reset_d   = 1'b0;
    core_start_d   = 1'b0;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;
    job_count_d    = job_count_q;
    to_cnt_d       = to_cnt_q;
    timeout_set    = 1'b0;

    // Pulse outputs are registered, so they are raised on the edge entering their state.
    case (state_q)
      S_IDLE: begin
        if (!empty && !digest_valid_q) begin
          state_d      = S_LOAD;
          core_reset_d = 1'b1;
        end
      end
      S_LOAD: begin
        core_block_d = build_block(fifo_mem[rd_ptr_q]);
        core_start_d = 1'b1;
        state_d      = S_START;
      end
      S_START: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          digest_d       = core_hash;
          digest_valid_d = 1'b1;
          job_count_d    = job_count_q + 16'd1;
          state_d        = S_HOLD;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_set  = 1'b1;
          core_reset_d = 1'b1;
          state_d      = S_ABORT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_ABORT: state_d = S_IDLE;
      S_HOLD: begin
        if (digest_ack) begin
          digest_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_set)    timeout_err_d = 1'b1;
    else if (err_clear) timeout_err_d = 1'b0;
    else                timeout_err_d = timeout_err_q;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= scan_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= S_IDLE;
      core_block_q   <= '0;
      core_reset_q   <= 1'b0;
      core_start_q   <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      job_count_q    <= '0;
      to_cnt_q       <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      core_block_q   <= core_block_d;
      core_reset_q   <= core_reset_d;
      core_start_q   <= core_start_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      timeout_err_q  <= timeout_err_d;
      job_count_q    <= job_count_d;
      to_cnt_q       <= to_cnt_d;
    end
  end

  assign scan_ready   = !full;
  assign busy         = (state_q != S_IDLE) || !empty;
  assign core_block   = core_block_q;
  assign core_reset   = core_reset_q;
  assign core_start   = core_start_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;
  assign timeout_err  = timeout_err_q;
  assign job_count    = job_count_q;

endmodule

// File: doc/hash_job_sequencer.md
Name: hash_job_sequencer

Overview:
- Sequences the SHA-256 hashing datapath for scanner traffic.
- Buffers 32-bit scanner words in a small FIFO and pops one word per job.
- For each job: builds the padded 512-bit single-block message, clears and starts the hash core, waits for done, then captures the 256-bit digest.
- Holds each digest for the NIOS-side register interface until acknowledged. Sits between the scanner front end, the hash core and the NIOS bus decoder.

Parameters:
FIFO_DEPTH, 4, scanner word buffer depth; power of two, 2..16
TIMEOUT_CYCLES, 1024, max cycles in WAIT before the job is abandoned; must be >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
scan_data  in  32  scanner word
scan_valid  in  1  scan_data valid
scan_ready  out  1  FIFO can accept; equals !full
core_block  out  512  padded block to hash core
core_reset  out  1  one-cycle clear pulse to hash core
core_start  out  1  one-cycle start pulse to hash core
core_done  in  1  hash core done, level
core_hash  in  256  hash core result
digest  out  256  captured digest
digest_valid  out  1  digest held, awaiting ack
digest_ack  in  1  NIOS consumed digest
err_clear  in  1  clears timeout_err
timeout_err  out  1  sticky: a job timed out
busy  out  1  state != IDLE or FIFO non-empty
job_count  out  16  completed jobs, wraps 0xFFFF->0

Behaviour:
- Interface: one clock (clk), reset is synchronous and active-high (reset).
- Reset values: FIFO empty, scan_ready=1, state IDLE, core_block=0, core_reset=0, core_start=0, digest=0, digest_valid=0, timeout_err=0, busy=0, job_count=0. Reset mid-job abandons the job with no core_start or core_reset pulse issued.
- FIFO push occurs on a rising edge with scan_valid && scan_ready. While full, scan_ready=0 and scan_valid is ignored; no overwrite.
- Pop happens only in LOAD. Push and pop in the same cycle are both honoured; count is unchanged.
- Block format: core_block = {word, 1'b1, 415'b0, 64'd32}. Registered in LOAD and stable until the next LOAD.
- FSM:
  - IDLE: go to LOAD when FIFO non-empty && !digest_valid.
  - LOAD: pop word, register core_block, core_reset=1 for this cycle only; go to START.
  - START: core_start=1 for this cycle only; clear timeout counter; go to WAIT.
  - WAIT: on core_done=1, digest<=core_hash, digest_valid<=1, job_count+1, go to HOLD. On counter == TIMEOUT_CYCLES-1 without done, timeout_err<=1, go to ABORT. core_done wins if both occur in the same cycle.
  - ABORT: core_reset=1 for one cycle; word is discarded, job_count unchanged; go to IDLE.
  - HOLD: on digest_ack, digest_valid<=0, go to IDLE. digest stays held after ack until the next capture.
- Latency: word accepted at edge k into an empty FIFO with the FSM in IDLE -> LOAD during cycle k+1, START (core_start high) during cycle k+2, WAIT from k+3. digest_valid rises on the edge after core_done is first seen high in WAIT.
- digest_ack outside HOLD is ignored.
- err_clear clears timeout_err. If a timeout sets in the same cycle, set wins.
- core_done outside WAIT is ignored.
- A FIFO full while HOLD is pending is legal: backpressure via scan_ready until ack.

Test Plan:
- Single job: push 0xDEADBEEF, core_done 5 cycles after core_start with core_hash=H -> core_block={32'hDEADBEEF,1'b1,415'b0,64'd32}; core_reset one cycle, then core_start one cycle at k+2; digest=H, digest_valid=1, job_count=1; ack -> digest_valid=0, busy=0.
- Backpressure: hold digest_ack=0 and push 5 words with FIFO_DEPTH=4 -> first word popped into a job, next 4 fill FIFO, scan_ready=0; 6th word stalls. Each ack releases the next job in order; digests match words 1..5 in sequence.
- Timeout: never assert core_done -> after TIMEOUT_CYCLES in WAIT, timeout_err=1 and a core_reset pulse; job_count unchanged; next queued word proceeds normally. err_clear -> timeout_err=0.
- Simultaneous push/pop: FIFO holding 2 words, push in the LOAD cycle -> occupancy stays 2 and word order is preserved.
- Reset mid-WAIT: assert reset -> all outputs at reset values next cycle, FIFO empty, no core_start; a later core_done is ignored.
- Wrap: preload job_count to 0xFFFF via forced jobs, complete one job -> job_count=0x0000.
